// File: rtl/dmem_io_responder_if.sv
// Core M-stage data port bundle: store strobe, address, store data, load data.
// master = core side (drives request), slave = memory side (drives ReadDataM).
interface dmem_io_responder_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output ALUResultM,
    output WriteDataM,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  ALUResultM,
    input  WriteDataM,
    output ReadDataM
  );
endinterface

// File: rtl/dmem_io_responder.sv
// Data-port responder: word RAM at 0x000-0x3FF plus LED/SW/timer IO at 0x400.
// Ports: clk, reset (async high), bus (slave), SwitchesIn, LedsOut, TimerIrq.
// DMEM_TIMER_EN builds the compare timer; otherwise its regs read 0.
module dmem_io_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_io_responder_if.slave    bus,
  input  logic [GPIO_WIDTH-1:0] SwitchesIn,
  output logic [GPIO_WIDTH-1:0] LedsOut,
  output logic                  TimerIrq
);

  localparam int IW =
    (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  assign addr  = bus.ALUResultM;
  assign wdata = bus.WriteDataM;
  assign we    = bus.MemWriteM;

  logic          ram_sel;
  logic          io_sel;
  logic [2:0]    rsel;
  logic [IW-1:0] widx;
  assign ram_sel = (addr[31:10] == 22'd0);
  assign io_sel  = (addr[31:8] == 24'h000004);
  assign rsel    = addr[4:2];
  assign widx    = addr[2 +: IW] & IW'(RAM_WORDS - 1);

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], addr[9:2]};

  logic sel_led, sel_sw, sel_cnt;
  logic sel_cmp, sel_ctrl, sel_stat;
  assign sel_led  = io_sel && (rsel == 3'd0);
  assign sel_sw   = io_sel && (rsel == 3'd1);
  assign sel_cnt  = io_sel && (rsel == 3'd2);
  assign sel_cmp  = io_sel && (rsel == 3'd3);
  assign sel_ctrl = io_sel && (rsel == 3'd4);
  assign sel_stat = io_sel && (rsel == 3'd5);

  // RAM: not reset
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we && ram_sel)
      mem_q[widx] <= wdata;
  end

  // LED register and switch synchronizer
  logic [GPIO_WIDTH-1:0] led_q, led_d;
  logic [GPIO_WIDTH-1:0] sw1_q, sw2_q;

  always_comb begin
    led_d = led_q;
    if (we && sel_led)
      led_d = wdata[GPIO_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
    end else begin
      led_q <= led_d;
      sw1_q <= SwitchesIn;
      sw2_q <= sw1_q;
    end
  end

  assign LedsOut = led_q;

  logic [31:0] led_ext, sw_ext;
  always_comb begin
    led_ext = '0;
    led_ext[GPIO_WIDTH-1:0] = led_q;
    sw_ext = '0;
    sw_ext[GPIO_WIDTH-1:0] = sw2_q;
  end

  logic [31:0] tcnt_rd, tcmp_rd;
  logic [31:0] tctrl_rd, tstat_rd;

`ifdef DMEM_TIMER_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [1:0]  tctrl_q, tctrl_d;
  logic        tstat_q, tstat_d;
  logic        match;

  // match compares pre-edge count; a count write beats both
  // increment and auto-clear, a match beats a W1C clear
  always_comb begin
    match   = tctrl_q[0] && (tcnt_q == tcmp_q);
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    tctrl_d = tctrl_q;
    tstat_d = tstat_q;
    if (we && sel_cnt)
      tcnt_d = wdata;
    else if (tctrl_q[0])
      tcnt_d = (match && tctrl_q[1]) ? 32'd0
                                     : tcnt_q + 32'd1;
    if (we && sel_cmp)
      tcmp_d = wdata;
    if (we && sel_ctrl)
      tctrl_d = wdata[1:0];
    if (we && sel_stat && wdata[0])
      tstat_d = 1'b0;
    if (match)
      tstat_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      tcmp_q  <= '1;
      tctrl_q <= '0;
      tstat_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
      tstat_q <= tstat_d;
    end
  end

  assign tcnt_rd  = tcnt_q;
  assign tcmp_rd  = tcmp_q;
  assign tctrl_rd = {30'd0, tctrl_q};
  assign tstat_rd = {31'd0, tstat_q};
  assign TimerIrq = tstat_q;
`else
  assign tcnt_rd  = '0;
  assign tcmp_rd  = '0;
  assign tctrl_rd = '0;
  assign tstat_rd = '0;
  assign TimerIrq = 1'b0;
`endif

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      ram_sel:  rdata = mem_q[widx];
      sel_led:  rdata = led_ext;
      sel_sw:   rdata = sw_ext;
      sel_cnt:  rdata = tcnt_rd;
      sel_cmp:  rdata = tcmp_rd;
      sel_ctrl: rdata = tctrl_rd;
      sel_stat: rdata = tstat_rd;
      default:  rdata = '0;
    endcase
  end

  assign bus.ReadDataM = rdata;

endmodule
